// File: rtl/stt_pkg.sv
// Shared types and constants for the speed_to_timing engine arbiter.
package stt_pkg;

  localparam int unsigned NUM_AXES = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 16;

  // Result word positions inside res_params / eng_params
  localparam int unsigned P_N     = 0;
  localparam int unsigned P_NN    = 1;
  localparam int unsigned P_T0    = 2;
  localparam int unsigned P_TNA   = 3;
  localparam int unsigned P_DELTA = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] num;
    logic [DATA_W-1:0] speed;
    logic [DATA_W-1:0] accel;
    logic [DATA_W-1:0] jerk;
  } eng_ops_t;

  typedef logic [NUM_AXES-1:0][DATA_W-1:0] params_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after last_grant+1.
module rr_pick #(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  int unsigned cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_grant) + k) % NUM_REQ;
      if (!grant_valid && req[IDX_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/stt_arbiter.sv
// Round-robin arbiter sharing one speed_to_timing engine among NUM_REQ requesters,
// with a wait timeout and an enforced idle gap between engine jobs.
module stt_arbiter
  import stt_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 5,
  parameter int unsigned GAP_CYCLES = 20,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_num,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_speed,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_accel,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_jerk,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             err,
  output params_t                        res_params,
  output logic                           busy,
  output logic                           eng_start,
  output logic [DATA_W-1:0]              eng_num,
  output logic [DATA_W-1:0]              eng_speed,
  output logic [DATA_W-1:0]              eng_accel,
  output logic [DATA_W-1:0]              eng_jerk,
  input  params_t                        eng_params,
  input  logic                           eng_finish
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  // A zero gap still spends one cycle in GAP
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
  eng_ops_t             ops_q, ops_d;
  params_t              res_q, res_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;

  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    ops_d        = ops_q;
    res_d        = res_q;
    start_d      = start_q;
    done_d       = '0;
    err_d        = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = WAIT;
          last_grant_d = grant_idx;
          ops_d.num    = req_num[grant_idx];
          ops_d.speed  = req_speed[grant_idx];
          ops_d.accel  = req_accel[grant_idx];
          ops_d.jerk   = req_jerk[grant_idx];
          start_d      = 1'b1;
          wait_cnt_d   = '0;
        end
      end
      WAIT: begin
        // Finish takes priority over a timeout in the same cycle
        if (eng_finish) begin
          res_d                = eng_params;
          done_d[last_grant_q] = 1'b1;
          start_d              = 1'b0;
          gap_cnt_d            = '0;
          state_d              = GAP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d[last_grant_q]  = 1'b1;
          start_d              = 1'b0;
          gap_cnt_d            = '0;
          state_d              = GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST && !eng_finish) begin
          state_d = IDLE;
        end else if (gap_cnt_q != GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      wait_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      ops_q        <= '0;
      res_q        <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      ops_q        <= ops_d;
      res_q        <= res_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign done       = done_q;
  assign err        = err_q;
  assign res_params = res_q;
  assign busy       = busy_q;
  assign eng_start  = start_q;
  assign eng_num    = ops_q.num;
  assign eng_speed  = ops_q.speed;
  assign eng_accel  = ops_q.accel;
  assign eng_jerk   = ops_q.jerk;

endmodule

// File: tb/tb_stt_arbiter.sv
// Bench for stt_arbiter: behavioural engine, job-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_stt_arbiter;
  import stt_pkg::*;

  localparam int NREQ = 5;
  localparam int GAP  = 20;
  localparam int TMO  = 100;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [NREQ-1:0]               req;
  logic [NREQ-1:0][31:0]         req_num, req_speed, req_accel, req_jerk;
  logic [NREQ-1:0]               done, err;
  logic [NUM_AXES-1:0][31:0]     res_params, eng_params;
  logic                          busy, eng_start, eng_finish;
  logic [31:0]                   eng_num, eng_speed, eng_accel, eng_jerk;

  always #5 clk = ~clk;

  stt_arbiter #(
    .NUM_REQ    (NREQ),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_num    (req_num),
    .req_speed  (req_speed),
    .req_accel  (req_accel),
    .req_jerk   (req_jerk),
    .done       (done),
    .err        (err),
    .res_params (res_params),
    .busy       (busy),
    .eng_start  (eng_start),
    .eng_num    (eng_num),
    .eng_speed  (eng_speed),
    .eng_accel  (eng_accel),
    .eng_jerk   (eng_jerk),
    .eng_params (eng_params),
    .eng_finish (eng_finish)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_num[i]   = $urandom;
      req_speed[i] = $urandom;
      req_accel[i] = $urandom;
      req_jerk[i]  = $urandom;
    end
  endtask

  // Behavioural engine: finish rises after eng_lat cycles of eng_start
  int  lat_fixed    = 11;
  bit  lat_rand     = 1'b0;
  bit  hold_forever = 1'b0;
  int  eng_cnt = 0, eng_lat = 0, hold_cnt = 0;
  logic [NUM_AXES-1:0][31:0] dir_params;

  initial begin
    eng_finish = 1'b0;
    eng_params = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        eng_cnt    = 0;
        eng_finish = 1'b0;
      end else if (eng_start) begin
        if (eng_cnt == 0) begin
          if (lat_rand) begin
            eng_lat  = ($urandom_range(0, 9) == 0) ? 100000 : int'($urandom_range(1, 30));
            hold_cnt = ($urandom_range(0, 6) == 0) ? int'($urandom_range(21, 35)) : 0;
          end else begin
            eng_lat  = lat_fixed;
            hold_cnt = 0;
          end
        end
        if (!eng_finish) begin
          eng_cnt++;
          if (eng_cnt >= eng_lat) begin
            eng_finish = 1'b1;
            if (lat_rand) for (int a = 0; a < NUM_AXES; a++) eng_params[a] = $urandom;
            else eng_params = dir_params;
          end
        end
      end else begin
        eng_cnt = 0;
        if (eng_finish && !hold_forever) begin
          if (hold_cnt > 0) hold_cnt--;
          else eng_finish = 1'b0;
        end
      end
    end
  end

  // Job-level reference model: who owns the engine, how long, and the idle gap
  int   m_owner, m_age, m_gap, m_last;
  bit   m_gapping, m_found;
  logic [NREQ-1:0]           m_done, m_err;
  logic                      m_busy, m_start;
  logic [31:0]               m_num, m_speed, m_accel, m_jerk;
  logic [NUM_AXES-1:0][31:0] m_res;

  task automatic model_clear();
    m_owner = -1; m_age = 0; m_gap = 0; m_last = NREQ - 1; m_gapping = 1'b0;
    m_done = '0; m_err = '0; m_busy = 1'b0; m_start = 1'b0;
    m_num = '0; m_speed = '0; m_accel = '0; m_jerk = '0; m_res = '0;
  endtask

  task automatic end_job();
    m_owner = -1; m_gapping = 1'b1; m_gap = 0; m_start = 1'b0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else begin
        m_done = '0;
        m_err  = '0;
        if (m_owner >= 0) begin
          if (eng_finish) begin
            m_res = eng_params;
            m_done[m_owner] = 1'b1;
            end_job();
          end else if (m_age + 1 >= TMO) begin
            m_err[m_owner] = 1'b1;
            end_job();
          end else m_age++;
        end else if (m_gapping) begin
          m_gap++;
          if (m_gap >= ((GAP == 0) ? 1 : GAP) && !eng_finish) begin
            m_gapping = 1'b0;
            m_busy    = 1'b0;
          end
        end else begin
          m_found = 1'b0;
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (!m_found && req[c]) begin
              m_found = 1'b1; m_owner = c; m_last = c; m_age = 0;
              m_start = 1'b1; m_busy = 1'b1;
              m_num = req_num[c]; m_speed = req_speed[c];
              m_accel = req_accel[c]; m_jerk = req_jerk[c];
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("busy", busy, m_busy);
      chk("eng_start", eng_start, m_start);
      chk("eng_ops", {eng_num, eng_speed, eng_accel, eng_jerk}, {m_num, m_speed, m_accel, m_jerk});
      chk("res_params", res_params, m_res);
    end
  end

  task automatic wait_job(input int budget, output int idx, output bit was_err);
    idx = -1;
    was_err = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((done | err) != '0) begin
        idx = onehot_idx(done | err);
        was_err = (err != '0);
        return;
      end
    end
    checks++; errors++;
    $display("FAIL wait_job: no done/err within %0d cycles", budget);
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++; errors++;
    $display("FAIL wait_idle: busy still high after %0d cycles", budget);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bit was_err;
    int s_first, s_last, s_cnt, d_cnt, d_k, e_k, de_cnt, n_jobs, n_rise;
    int order[5];
    int rise[5];
    logic prev_start;

    reset = 1'b1;
    req   = '0;
    drive_ops();
    dir_params[P_N] = 100; dir_params[P_NN] = 50; dir_params[P_T0] = 7;
    dir_params[P_TNA] = 3; dir_params[P_DELTA] = 2;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_res", res_params, 0);
    chk("rst_num", eng_num, 0);

    // Single requester, engine finishes in its 11th cycle of eng_start
    reset = 1'b1; req = 5'b00001; lat_fixed = 11;
    s_first = -1; s_last = -1; s_cnt = 0; d_cnt = 0; d_k = -1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      drive_ops();
      if (eng_start) begin
        if (s_first < 0) s_first = k;
        s_last = k; s_cnt++;
      end
      if (done != '0) begin
        d_cnt++; d_k = k; req = '0;
        chk("A_done_bits", done, 5'b00001);
        chk("A_res_N", res_params[P_N], 100);
        chk("A_res_NN", res_params[P_NN], 50);
        chk("A_res_T0", res_params[P_T0], 7);
        chk("A_res_TNA", res_params[P_TNA], 3);
        chk("A_res_DELTA", res_params[P_DELTA], 2);
      end
    end
    chk("A_start_first", s_first, 1);
    chk("A_start_last", s_last, 11);
    chk("A_start_cnt", s_cnt, 11);
    chk("A_done_cycle", d_k, 12);
    chk("A_done_cnt", d_cnt, 1);
    wait_idle(60);

    // Round-robin after last grant 0: 2 before 0, then 0 before re-granting 2
    dir_params[P_N] = 11; dir_params[P_NN] = 22; dir_params[P_T0] = 33;
    dir_params[P_TNA] = 44; dir_params[P_DELTA] = 55;
    lat_fixed = 4; req = 5'b00101;
    wait_job(100, idx, was_err);
    chk("B_first", idx, 2);
    wait_job(100, idx, was_err);
    chk("B_second", idx, 0);
    req = '0;
    wait_idle(60);

    // Finish stuck high after done keeps the arbiter in GAP
    hold_forever = 1'b1; req = 5'b00010;
    wait_job(100, idx, was_err);
    chk("C_grant", idx, 1);
    req = '0;
    repeat (30) @(negedge clk);
    chk("C_busy_held", busy, 1);
    hold_forever = 1'b0;
    repeat (3) @(negedge clk);
    chk("C_idle", busy, 0);

    // Engine never finishes: err after 100 WAIT cycles, result kept, 20-cycle gap
    lat_fixed = 100000; req = 5'b00100;
    s_cnt = 0; e_k = -1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (eng_start) s_cnt++;
      if (err != '0 && e_k < 0) begin
        e_k = k; req = '0;
        chk("D_err_bits", err, 5'b00100);
        chk("D_res_kept", res_params, dir_params);
      end
      if (k == 120) chk("D_busy_gap_end", busy, 1);
      if (k == 121) chk("D_idle_after_gap", busy, 0);
    end
    chk("D_err_cycle", e_k, 101);
    chk("D_start_cnt", s_cnt, 100);

    // Reset mid-WAIT: eng_start drops asynchronously, job discarded
    req = 5'b00100;
    for (int k = 0; k < 10 && !eng_start; k++) @(negedge clk);
    chk("E_started", eng_start, 1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("E_start_async", eng_start, 0);
    chk("E_busy_async", busy, 0);
    req = '0;
    de_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if ((done | err) != '0) de_cnt++;
    end
    chk("E_no_pulse", de_cnt, 0);

    // All requesters from reset release: grants 0..4, spaced by the gap
    @(negedge clk);
    reset = 1'b1; req = 5'b11111; lat_fixed = 5;
    n_jobs = 0; n_rise = 0; prev_start = 1'b0;
    for (int k = 0; k < 400 && n_jobs < 5; k++) begin
      @(negedge clk);
      if (eng_start && !prev_start && n_rise < 5) begin
        rise[n_rise] = k; n_rise++;
      end
      prev_start = eng_start;
      if (done != '0) begin
        order[n_jobs] = onehot_idx(done); n_jobs++;
      end
    end
    chk("E_jobs", n_jobs, 5);
    for (int i = 0; i < n_jobs; i++) chk("E_order", order[i], i);
    for (int i = 1; i < n_rise; i++) chk("E_spacing", (rise[i] - rise[i-1]) >= 20, 1);

    // Random traffic: holds, drops, re-requests, timeouts and sticky finish
    lat_rand = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      drive_ops();
      for (int i = 0; i < NREQ; i++) begin
        if (done[i] || err[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 199) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
      end
    end
    req = '0;
    wait_idle(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
